logic_unit_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32-bit logic unit (AND/OR/XOR/NOR) between NUM_REQ requesters, e.g. the EX-stage ALU path and a branch/compare helper.
- Each requester uses a valid/ready handshake to present an op code and two operands.
- The block selects one requester per cycle, computes the logic result, and registers it in a one-entry output stage with its own valid/ready handshake.

---
 rtl/logic_unit_arbiter_pkg.sv | 29 ++
 rtl/logic_unit_arbiter_if.sv | 42 ++++
 rtl/logic_unit_arbiter_rr_arbiter.sv | 48 ++++
 rtl/logic_unit_arbiter.sv | 96 +++++++++
 tb/tb_logic_unit_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic unit arbiter: op codes, data width, output
// stage state type and the 32-bit logic function.
package logic_unit_arbiter_pkg;

  localparam int unsigned LU_DATA_W = 32;

  localparam logic [1:0] LU_OP_AND = 2'b00;
  localparam logic [1:0] LU_OP_OR  = 2'b01;
  localparam logic [1:0] LU_OP_XOR = 2'b10;
  localparam logic [1:0] LU_OP_NOR = 2'b11;

  // Occupancy of the one-entry output stage.
  typedef enum logic {StEmpty, StFull} lu_state_e;

  function automatic logic [LU_DATA_W-1:0] lu_compute(input logic [1:0]           op,
                                                      input logic [LU_DATA_W-1:0] x,
                                                      input logic [LU_DATA_W-1:0] y);
    logic [LU_DATA_W-1:0] res;
    res = '0;
    unique case (op)
      LU_OP_AND: res = x & y;
      LU_OP_OR:  res = x | y;
      LU_OP_XOR: res = x ^ y;
      LU_OP_NOR: res = ~(x | y);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Bundle of requester and response handshake signals for logic_unit_arbiter.
//   master: requesters + downstream consumer (drive req_*, resp_ready)
//   slave:  the arbiter (drives req_ready, resp_valid, resp_data, resp_id)
// Optional macro LU_ARB_ZERO_FLAG_EN adds resp_zero (result == 0).
interface logic_unit_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
);
  import logic_unit_arbiter_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [2*NUM_REQ-1:0]         req_op;
  logic [LU_DATA_W*NUM_REQ-1:0] req_x;
  logic [LU_DATA_W*NUM_REQ-1:0] req_y;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [LU_DATA_W-1:0]         resp_data;
  logic [ID_W-1:0]              resp_id;
`ifdef LU_ARB_ZERO_FLAG_EN
  logic                         resp_zero;

  modport master (
    output req_valid, req_op, req_x, req_y, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_zero
  );
  modport slave (
    input  req_valid, req_op, req_x, req_y, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_zero
  );
`else
  modport master (
    output req_valid, req_op, req_x, req_y, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );
  modport slave (
    input  req_valid, req_op, req_x, req_y, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
`endif

endinterface

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Round-robin arbiter. Scans req starting one past last_grant, wrapping; the
// first set bit wins. last_grant updates only when advance is asserted.
//   clk, reset : clock, async active-high reset
//   req        : request vector
//   advance    : the current grant was accepted this cycle
//   grant      : one-hot (or zero) grant, combinational
//   grant_id   : index of the granted requester
module rr_arbiter #(
  parameter int unsigned N   = 2,
  parameter int unsigned IdW = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IdW-1:0] grant_id
);

  logic [IdW-1:0] last_grant_q;
  logic [IdW-1:0] idx;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IdW'((32'(last_grant_q) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

  // Reset to N-1 so requester 0 is first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IdW'(N - 1);
    end else if (advance) begin
      last_grant_q <= grant_id;
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one 32-bit logic unit (AND/OR/XOR/NOR) between NUM_REQ requesters
// with round-robin arbitration and a one-entry registered output stage.
//   clk   : clock
//   reset : async active-high reset
//   bus   : logic_unit_arbiter_if.slave (request and response handshakes)
// Optional macro LU_ARB_ZERO_FLAG_EN: registered resp_zero flag.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input logic                  clk,
  input logic                  reset,
  logic_unit_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 can_accept;
  logic                 accept;
  logic [1:0]           sel_op;
  logic [LU_DATA_W-1:0] sel_x;
  logic [LU_DATA_W-1:0] sel_y;
  logic [LU_DATA_W-1:0] result;

  lu_state_e            state_q;
  logic [LU_DATA_W-1:0] data_q;
  logic [ID_W-1:0]      id_q;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IdW (ID_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Output stage can drain and refill in the same cycle.
  assign can_accept    = (state_q == StEmpty) || bus.resp_ready;
  assign bus.req_ready = grant & {NUM_REQ{can_accept}};
  assign accept        = |bus.req_ready;

  // One-hot operand mux driven by the grant vector.
  always_comb begin
    sel_op = '0;
    sel_x  = '0;
    sel_y  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = bus.req_op[2*i +: 2];
        sel_x  = bus.req_x[LU_DATA_W*i +: LU_DATA_W];
        sel_y  = bus.req_y[LU_DATA_W*i +: LU_DATA_W];
      end
    end
  end

  assign result = lu_compute(sel_op, sel_x, sel_y);

`ifdef LU_ARB_ZERO_FLAG_EN
  logic zero_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      id_q    <= '0;
`ifdef LU_ARB_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= StFull;
      data_q  <= result;
      id_q    <= grant_id;
`ifdef LU_ARB_ZERO_FLAG_EN
      zero_q  <= (result == '0);
`endif
    end else if (bus.resp_ready) begin
      // Drain only; data and id keep their last values.
      state_q <= StEmpty;
    end
  end

  assign bus.resp_valid = (state_q == StFull);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;
`ifdef LU_ARB_ZERO_FLAG_EN
  assign bus.resp_zero  = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter (NUM_REQ=2). Optional macro
// LU_ARB_ZERO_FLAG_EN enables the resp_zero checks.
module tb_logic_unit_arbiter;
  import logic_unit_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  logic_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [31:0] x, input logic [31:0] y);
    bus.req_valid[i]       = v;
    bus.req_op[2*i +: 2]   = op;
    bus.req_x[32*i +: 32]  = x;
    bus.req_y[32*i +: 32]  = y;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic [31:0] d,
                            input logic [31:0] id);
    check({tag, "_valid"}, 32'(bus.resp_valid), 32'(v));
    check({tag, "_data"}, bus.resp_data, d);
    check({tag, "_id"}, 32'(bus.resp_id), id);
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_resp("reset", 1'b0, 32'h0, 32'd0);
    check("reset_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b0;

    // Single request on requester 0, AND
    set_req(0, 1'b1, LU_OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h1);
    step();
    check_resp("single", 1'b1, 32'hF000F000, 32'd0);

    // Op coverage on requester 1
    set_req(0, 1'b0, LU_OP_AND, 32'h0, 32'h0);
    set_req(1, 1'b1, LU_OP_OR, 32'h0000FFFF, 32'h00FF00FF);
    #1;
    check("or_ready", 32'(bus.req_ready), 32'h2);
    step();
    check_resp("or", 1'b1, 32'h00FFFFFF, 32'd1);
    set_req(1, 1'b1, LU_OP_XOR, 32'h0000FFFF, 32'h00FF00FF);
    step();
    check_resp("xor", 1'b1, 32'h00FFFF00, 32'd1);
    set_req(1, 1'b1, LU_OP_NOR, 32'h0000FFFF, 32'h00FF00FF);
    step();
    check_resp("nor", 1'b1, 32'hFF000000, 32'd1);

    // Drain without accept: valid drops, data/id hold
    set_req(1, 1'b0, LU_OP_AND, 32'h0, 32'h0);
    #1;
    check("drain_ready", 32'(bus.req_ready), 32'h0);
    step();
    check_resp("drain", 1'b0, 32'hFF000000, 32'd1);

    // Contention: alternate 0,1,0,1
    set_req(0, 1'b1, LU_OP_AND, 32'hFFFFFFFF, 32'h0000000F);
    set_req(1, 1'b1, LU_OP_OR, 32'h00000000, 32'h00000010);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check_resp("rr", 1'b1, (k % 2 == 0) ? 32'h0000000F : 32'h00000010, 32'(k % 2));
    end

    // Backpressure: 3 stalled cycles hold everything
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 32'(bus.req_ready), 32'h0);
      step();
      check_resp("stall", 1'b1, 32'h00000010, 32'd1);
    end
    // Release: drain and accept in the same cycle
    bus.resp_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(bus.req_ready), 32'h1);
    step();
    check_resp("unstall", 1'b1, 32'h0000000F, 32'd0);

    // Reset mid-stall clears the output stage immediately
    bus.resp_ready = 1'b0;
    step();
    check_resp("prerst", 1'b1, 32'h0000000F, 32'd0);
    reset = 1'b1;
    #1;
    check_resp("midrst", 1'b0, 32'h0, 32'd0);
    step();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    #1;
    // last_grant was 0 before reset; after reset requester 0 wins again
    check("postrst_ready", 32'(bus.req_ready), 32'h1);
    step();
    check_resp("postrst", 1'b1, 32'h0000000F, 32'd0);
    check("postrst_ready2", 32'(bus.req_ready), 32'h2);

    // Zero-flag vectors
    set_req(0, 1'b1, LU_OP_AND, 32'hAAAAAAAA, 32'h55555555);
    set_req(1, 1'b0, LU_OP_AND, 32'h0, 32'h0);
    step();
    check_resp("and_zero", 1'b1, 32'h00000000, 32'd0);
`ifdef LU_ARB_ZERO_FLAG_EN
    check("zero_flag_set", 32'(bus.resp_zero), 32'h1);
`endif
    set_req(0, 1'b1, LU_OP_OR, 32'hAAAAAAAA, 32'h55555555);
    step();
    check_resp("or_ones", 1'b1, 32'hFFFFFFFF, 32'd0);
`ifdef LU_ARB_ZERO_FLAG_EN
    check("zero_flag_clr", 32'(bus.resp_zero), 32'h0);
`endif
    set_req(0, 1'b0, LU_OP_AND, 32'h0, 32'h0);
    step();
    check_resp("final_drain", 1'b0, 32'hFFFFFFFF, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
